// File: rtl/arm_ctrl_seq.sv
// arm_ctrl_seq -- instruction control sequencer.
// Accepts one decoded instruction at a time in IDLE, then steps it through
// EXEC / MUL / MEM / WB / TRAP and retires it with a one-cycle DONE pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ir, itype, cond_pass     instruction word, decoder class, condition result
//   ir_valid / ir_ready      issue handshake (ready only in IDLE)
//   alu_en, pc_load          ALU/multiplier active, PC load from ALU result
//   mem_req, mem_we, mem_ack memory access request / write / completion
//   rf_we, reg_idx           register-file write strobe and index (also beat index)
//   undef_trap, instr_done   trap pulse, retire pulse
module arm_ctrl_seq #(
    parameter int MUL_CYCLES  = 2,
    parameter int MULL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir,
    input  logic        ir_valid,
    output logic        ir_ready,
    input  logic [3:0]  itype,
    input  logic        cond_pass,
    output logic        alu_en,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        rf_we,
    output logic [3:0]  reg_idx,
    output logic        pc_load,
    output logic        undef_trap,
    output logic        instr_done
);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_MEM, S_WB, S_TRAP, S_DONE} state_t;

    localparam logic [3:0] C_MUL    = 4'd0;
    localparam logic [3:0] C_MULL   = 4'd1;
    localparam logic [3:0] C_BX     = 4'd2;
    localparam logic [3:0] C_SWAP   = 4'd3;
    localparam logic [3:0] C_HALFR  = 4'd4;
    localparam logic [3:0] C_HALFI  = 4'd5;
    localparam logic [3:0] C_SIGNED = 4'd6;
    localparam logic [3:0] C_DP     = 4'd7;
    localparam logic [3:0] C_LDST   = 4'd8;
    localparam logic [3:0] C_BLOCK  = 4'd10;
    localparam logic [3:0] C_BR     = 4'd11;

    state_t      state, state_nx;
    logic [31:0] ir_q;
    logic [3:0]  cls;
    logic [7:0]  cnt;
    logic        phase;     // swap: 0=read, 1=write; long-mul WB: 0=RdLo, 1=RdHi
    logic [15:0] mask;
    logic [3:0]  low_idx;
    logic        is_load, is_cmp, last_beat;
    logic        unused_bits;

    assign is_load     = ir_q[20];
    assign is_cmp      = (ir_q[24:23] == 2'b10);   // opcodes 1000..1011
    assign last_beat   = ((mask & (mask - 16'd1)) == 16'd0);
    assign unused_bits = ^{ir_q[31:25], ir_q[11:0]};

    // lowest set bit of the remaining block-transfer mask
    always_comb begin
        low_idx = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (mask[i]) low_idx = 4'(i);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // latched instruction, counters and mask
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q  <= '0;
            cls   <= '0;
            cnt   <= '0;
            phase <= 1'b0;
            mask  <= '0;
        end else begin
            case (state)
                S_IDLE: if (ir_valid) begin
                    ir_q  <= ir;
                    cls   <= itype;
                    mask  <= ir[15:0];
                    phase <= 1'b0;
                    cnt   <= (itype == C_MULL) ? 8'(MULL_CYCLES - 1) : 8'(MUL_CYCLES - 1);
                end
                S_MUL: if (cnt != 8'd0) cnt <= cnt - 8'd1;
                // mask only matters for block transfers, phase only for swap;
                // single accesses leave MEM on their one ack.
                S_MEM: if (mem_ack) begin
                    mask  <= mask & (mask - 16'd1);
                    phase <= 1'b1;
                end
                S_WB: phase <= ~phase;
                default: ;
            endcase
        end
    end

    // next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (ir_valid) begin
                if (!cond_pass) state_nx = S_DONE;
                else begin
                    case (itype)
                        C_DP, C_BX, C_BR: state_nx = S_EXEC;
                        C_MUL, C_MULL:    state_nx = S_MUL;
                        C_SWAP, C_HALFR, C_HALFI, C_SIGNED, C_LDST, C_BLOCK:
                                          state_nx = S_MEM;
                        default:          state_nx = S_TRAP;
                    endcase
                end
            end
            S_EXEC: state_nx = (cls == C_DP) ? S_WB : S_DONE;
            S_MUL:  if (cnt == 8'd0) state_nx = S_WB;
            S_MEM: begin
                if (cls == C_BLOCK) begin
                    if (mask == 16'd0 || (mem_ack && last_beat)) state_nx = S_DONE;
                end else if (mem_ack) begin
                    if (cls == C_SWAP) state_nx = phase ? S_WB : S_MEM;
                    else               state_nx = is_load ? S_WB : S_DONE;
                end
            end
            S_WB:   if (!(cls == C_MULL && !phase)) state_nx = S_DONE;
            S_TRAP: state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        ir_ready   = (state == S_IDLE);
        alu_en     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        rf_we      = 1'b0;
        reg_idx    = 4'd0;
        pc_load    = 1'b0;
        undef_trap = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_EXEC: begin
                alu_en = 1'b1;
                if (cls != C_DP) begin
                    pc_load = 1'b1;
                    if (cls == C_BR && ir_q[24]) begin   // branch-with-link writes LR
                        rf_we   = 1'b1;
                        reg_idx = 4'd14;
                    end
                end
            end
            S_MUL: alu_en = 1'b1;
            S_MEM: begin
                if (cls == C_BLOCK) begin
                    if (mask != 16'd0) begin
                        mem_req = 1'b1;
                        mem_we  = ~ir_q[20];
                        reg_idx = low_idx;
                        rf_we   = is_load & mem_ack & ~rst;
                    end
                end else begin
                    mem_req = 1'b1;
                    mem_we  = (cls == C_SWAP) ? phase : ~ir_q[20];
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                reg_idx = ir_q[15:12];
                case (cls)
                    C_MUL:  reg_idx = ir_q[19:16];
                    C_MULL: if (phase) reg_idx = ir_q[19:16];
                    C_DP:   rf_we = ~is_cmp;
                    default: ;
                endcase
            end
            S_TRAP: undef_trap = 1'b1;
            S_DONE: instr_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arm_ctrl_seq.sv
// Directed testbench for arm_ctrl_seq. Outputs are packed into one vector
// {ir_ready, alu_en, mem_req, mem_we, rf_we, pc_load, undef_trap, instr_done, reg_idx}
// and compared cycle by cycle against hand-written expected sequences.
module tb_arm_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic [3:0]  itype;
    logic        cond_pass;
    logic        alu_en, mem_req, mem_we, mem_ack, rf_we;
    logic [3:0]  reg_idx;
    logic        pc_load, undef_trap, instr_done;
    logic [11:0] obs;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    arm_ctrl_seq #(.MUL_CYCLES(2), .MULL_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .itype(itype), .cond_pass(cond_pass), .alu_en(alu_en), .mem_req(mem_req),
        .mem_we(mem_we), .mem_ack(mem_ack), .rf_we(rf_we), .reg_idx(reg_idx),
        .pc_load(pc_load), .undef_trap(undef_trap), .instr_done(instr_done)
    );

    assign obs = {ir_ready, alu_en, mem_req, mem_we, rf_we, pc_load, undef_trap, instr_done, reg_idx};

    function automatic logic [11:0] ov(input logic rdy, alu, mreq, mwe, rfwe, pcl, ut, dn,
                                       input logic [3:0] idx);
        return {rdy, alu, mreq, mwe, rfwe, pcl, ut, dn, idx};
    endfunction

    // present one instruction in IDLE; returns #1 after the accepting edge
    task automatic issue(input logic [31:0] w, input logic [3:0] t, input logic c);
        ir = w; itype = t; cond_pass = c; ir_valid = 1'b1;
        @(posedge clk); #1;
        ir_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ir = '0; itype = '0; cond_pass = 1'b0; ir_valid = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== ov(1,0,0,0,0,0,0,0,0)) begin errors++; $display("FAIL reset_held: got %h want %h", obs, ov(1,0,0,0,0,0,0,0,0)); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs !== ov(1,0,0,0,0,0,0,0,0)) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, ov(1,0,0,0,0,0,0,0,0)); end
    endtask

    task automatic test_dataproc();
        logic [11:0] e [4];
        e[0] = ov(0,1,0,0,0,0,0,0,0); e[1] = ov(0,0,0,0,1,0,0,0,2);
        e[2] = ov(0,0,0,0,0,0,0,1,0); e[3] = ov(1,0,0,0,0,0,0,0,0);
        issue(32'hE0812003, 4'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL dataproc c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_compare();
        logic [11:0] e [4];
        e[0] = ov(0,1,0,0,0,0,0,0,0); e[1] = ov(0,0,0,0,0,0,0,0,0);
        e[2] = ov(0,0,0,0,0,0,0,1,0); e[3] = ov(1,0,0,0,0,0,0,0,0);
        issue(32'hE1510002, 4'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL compare c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_block_load();
        logic [11:0] e [11];
        logic        a [11];
        for (int b = 0; b < 3; b++) begin
            e[3*b]   = ov(0,0,1,0,0,0,0,0,4'(2*b)); a[3*b]   = 1'b0;
            e[3*b+1] = ov(0,0,1,0,0,0,0,0,4'(2*b)); a[3*b+1] = 1'b0;
            e[3*b+2] = ov(0,0,1,0,1,0,0,0,4'(2*b)); a[3*b+2] = 1'b1;
        end
        e[9] = ov(0,0,0,0,0,0,0,1,0); a[9] = 1'b0;
        e[10] = ov(1,0,0,0,0,0,0,0,0); a[10] = 1'b0;
        issue(32'hE8BD0015, 4'd10, 1'b1);
        for (int i = 0; i < 11; i++) begin
            mem_ack = a[i]; #1;
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL block_load c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_block_zero_mask();
        logic [11:0] e [3];
        e[0] = ov(0,0,0,0,0,0,0,0,0); e[1] = ov(0,0,0,0,0,0,0,1,0); e[2] = ov(1,0,0,0,0,0,0,0,0);
        issue(32'hE8BD0000, 4'd10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL block_zero c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mul();
        logic [11:0] e [5];
        logic [11:0] f [7];
        e[0] = ov(0,1,0,0,0,0,0,0,0); e[1] = ov(0,1,0,0,0,0,0,0,0);
        e[2] = ov(0,0,0,0,1,0,0,0,5); e[3] = ov(0,0,0,0,0,0,0,1,0); e[4] = ov(1,0,0,0,0,0,0,0,0);
        issue(32'h00A54291, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL mul c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        f[0] = ov(0,1,0,0,0,0,0,0,0); f[1] = ov(0,1,0,0,0,0,0,0,0); f[2] = ov(0,1,0,0,0,0,0,0,0);
        f[3] = ov(0,0,0,0,1,0,0,0,4); f[4] = ov(0,0,0,0,1,0,0,0,5);
        f[5] = ov(0,0,0,0,0,0,0,1,0); f[6] = ov(1,0,0,0,0,0,0,0,0);
        issue(32'h00A54291, 4'd1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs !== f[i]) begin errors++; $display("FAIL mull c%0d: got %h want %h", i, obs, f[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_mem();
        logic [11:0] e [4];
        logic        a [4];
        // store: one wait cycle, then ack, then retire
        e[0] = ov(0,0,1,1,0,0,0,0,0); a[0] = 1'b0;
        e[1] = ov(0,0,1,1,0,0,0,0,0); a[1] = 1'b1;
        e[2] = ov(0,0,0,0,0,0,0,1,0); a[2] = 1'b0;
        e[3] = ov(1,0,0,0,0,0,0,0,0); a[3] = 1'b0;
        issue(32'hE5801000, 4'd8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            mem_ack = a[i]; #1;
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL store c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        // load: immediate ack, WB to r3
        e[0] = ov(0,0,1,0,0,0,0,0,0); a[0] = 1'b1;
        e[1] = ov(0,0,0,0,1,0,0,0,3); a[1] = 1'b0;
        e[2] = ov(0,0,0,0,0,0,0,1,0); a[2] = 1'b0;
        e[3] = ov(1,0,0,0,0,0,0,0,0); a[3] = 1'b0;
        issue(32'hE5913000, 4'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            mem_ack = a[i]; #1;
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL load c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_swap();
        logic [11:0] e [6];
        logic        a [6];
        e[0] = ov(0,0,1,0,0,0,0,0,0); a[0] = 1'b0;
        e[1] = ov(0,0,1,0,0,0,0,0,0); a[1] = 1'b1;
        e[2] = ov(0,0,1,1,0,0,0,0,0); a[2] = 1'b1;
        e[3] = ov(0,0,0,0,1,0,0,0,5); a[3] = 1'b0;
        e[4] = ov(0,0,0,0,0,0,0,1,0); a[4] = 1'b0;
        e[5] = ov(1,0,0,0,0,0,0,0,0); a[5] = 1'b0;
        issue(32'hE1025091, 4'd3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            mem_ack = a[i]; #1;
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL swap c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_branch();
        logic [11:0] e [3];
        e[0] = ov(0,1,0,0,1,1,0,0,14); e[1] = ov(0,0,0,0,0,0,0,1,0); e[2] = ov(1,0,0,0,0,0,0,0,0);
        issue(32'hEB000010, 4'd11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL bl c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        e[0] = ov(0,1,0,0,0,1,0,0,0);
        issue(32'hE12FFF1E, 4'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL bx c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_undef_cond();
        logic [11:0] e [3];
        logic [11:0] f [2];
        e[0] = ov(0,0,0,0,0,0,1,0,0); e[1] = ov(0,0,0,0,0,0,0,1,0); e[2] = ov(1,0,0,0,0,0,0,0,0);
        issue(32'hEE000000, 4'd12, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL coproc c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        issue(32'hE7F000F0, 4'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL undef c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        f[0] = ov(0,0,0,0,0,0,0,1,0); f[1] = ov(1,0,0,0,0,0,0,0,0);
        issue(32'h05913000, 4'd8, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs !== f[i]) begin errors++; $display("FAIL condfail_ld c%0d: got %h want %h", i, obs, f[i]); end
            @(posedge clk); #1;
        end
        issue(32'h18BD0015, 4'd10, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs !== f[i]) begin errors++; $display("FAIL condfail_blk c%0d: got %h want %h", i, obs, f[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_block();
        issue(32'hE8BD0015, 4'd10, 1'b1);
        mem_ack = 1'b1; #1;
        checks++;
        if (obs !== ov(0,0,1,0,1,0,0,0,0)) begin errors++; $display("FAIL rstblk_beat0: got %h want %h", obs, ov(0,0,1,0,1,0,0,0,0)); end
        @(posedge clk); #1;
        mem_ack = 1'b0; #1;
        checks++;
        if (obs !== ov(0,0,1,0,0,0,0,0,2)) begin errors++; $display("FAIL rstblk_beat1: got %h want %h", obs, ov(0,0,1,0,0,0,0,0,2)); end
        rst = 1'b1; mem_ack = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== ov(1,0,0,0,0,0,0,0,0)) begin errors++; $display("FAIL rstblk_after c%0d: got %h want %h", i, obs, ov(1,0,0,0,0,0,0,0,0)); end
            @(posedge clk); #1;
        end
    endtask

    // ir_valid held high and ir changed mid-flight; mem_ack asserted outside MEM
    task automatic test_back_to_back();
        logic [11:0] e [8];
        e[0] = ov(0,1,0,0,0,0,0,0,0); e[1] = ov(0,0,0,0,1,0,0,0,2);
        e[2] = ov(0,0,0,0,0,0,0,1,0); e[3] = ov(1,0,0,0,0,0,0,0,0);
        e[4] = ov(0,1,0,0,0,0,0,0,0); e[5] = ov(0,0,0,0,1,0,0,0,7);
        e[6] = ov(0,0,0,0,0,0,0,1,0); e[7] = ov(1,0,0,0,0,0,0,0,0);
        mem_ack = 1'b1;
        ir = 32'hE0812003; itype = 4'd7; cond_pass = 1'b1; ir_valid = 1'b1;
        @(posedge clk); #1;
        ir = 32'hE0817003;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL b2b c%0d: got %h want %h", i, obs, e[i]); end
            @(posedge clk); #1;
            if (i == 3) ir_valid = 1'b0;
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dataproc();
        test_compare();
        test_block_load();
        test_block_zero_mask();
        test_mul();
        test_single_mem();
        test_swap();
        test_branch();
        test_undef_cond();
        test_reset_mid_block();
        test_dataproc();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_ctrl_seq.md
ARM_CTRL_SEQ -- requirements
Module: arm_ctrl_seq

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 2: the number of MUL-state cycles for class 0 (multiply).
REQ-002 SHALL have parameter MULL_CYCLES, default 3: the number of MUL-state cycles for class 1 (multiplyLong).
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ir  input  32  instruction word offered for issue.
REQ-006 SHALL have port ir_valid  input  1  ir and itype are valid.
REQ-007 SHALL have port ir_ready  output  1  sequencer can accept an instruction.
REQ-008 SHALL have port itype  input  4  decoder class code, coded as follows:
- 0 = mul, 1 = mull, 2 = bx, 3 = swap
- 4 = halfR, 5 = halfI, 6 = signed, 7 = dataProc
- 8 = ldst, 9 = undef, 10 = block, 11 = branch, 12 = coproc
REQ-009 SHALL have port cond_pass  input  1  condition-code check result, valid with ir_valid.
REQ-010 SHALL have port alu_en  output  1  ALU/multiplier active this cycle.
REQ-011 SHALL have port mem_req  output  1  memory access request.
REQ-012 SHALL have port mem_we  output  1  the access is a write.
REQ-013 SHALL have port mem_ack  input  1  access completes this cycle.
REQ-014 SHALL have port rf_we  output  1  register-file write strobe.
REQ-015 SHALL have port reg_idx  output  4  register-file index for rf_we or for the current transfer beat.
REQ-016 SHALL have port pc_load  output  1  load the PC from the ALU result.
REQ-017 SHALL have port undef_trap  output  1  one-cycle undefined-instruction trap pulse.
REQ-018 SHALL have port instr_done  output  1  one-cycle retire pulse.

Function
REQ-019 SHALL use states IDLE, EXEC, MUL, MEM, WB, TRAP and DONE; all outputs SHALL be decoded from the registered state, counters and latched ir.
REQ-020 SHALL drive ir_ready=1 only in IDLE; on ir_valid&ir_ready it SHALL latch ir and itype, and ir_valid SHALL be ignored in every other state.
REQ-021 When cond_pass=0 at accept, it SHALL go IDLE->DONE with no other strobes.
REQ-022 Class 7: SHALL sequence EXEC (alu_en) -> WB -> DONE.
- WB drives rf_we=1 with reg_idx=ir[15:12], except when ir[24:21] is in 1000..1011 (compare ops), where rf_we=0.
REQ-023 Classes 0/1: SHALL spend MUL_CYCLES or MULL_CYCLES cycles in MUL with alu_en=1, using a down-counter.
- Class 0 then does one WB cycle with reg_idx=ir[19:16].
- Class 1 then does two WB cycles: ir[15:12] first, then ir[19:16].
- Each of these is followed by DONE.
REQ-024 Classes 3/4/5/6/8: SHALL enter MEM and hold mem_req=1 with a stable mem_we until mem_ack=1.
- mem_we = ~ir[20].
- A load (ir[20]=1) goes to WB with reg_idx=ir[15:12]; a store goes to DONE.
REQ-025 Class 3 (swap): SHALL perform two accesses, a read (mem_we=0) then a write (mem_we=1), then WB with reg_idx=ir[15:12].
REQ-026 Class 10 (block): SHALL keep a 16-bit remaining-mask loaded from ir[15:0].
- One beat per set bit, in ascending order; reg_idx = lowest set bit.
- On mem_ack, that bit is cleared; for a load (ir[20]=1), rf_we=1 in the same ack cycle.
- After the last beat it goes to DONE; if the mask is zero, it goes MEM->DONE with no mem_req.
REQ-027 Classes 2/11: SHALL spend one EXEC cycle with alu_en=1 and pc_load=1, then go to DONE.
- Class 11 with ir[24]=1 also drives rf_we=1 with reg_idx=14 in that cycle.
REQ-028 Classes 9/12: SHALL spend one TRAP cycle with undef_trap=1, then go to DONE; there is no coprocessor support.
REQ-029 In DONE it SHALL drive instr_done=1 for exactly one cycle, then return to IDLE; back-to-back issue is therefore possible no sooner than the cycle after DONE.
REQ-030 mem_ack SHALL be ignored outside MEM, and a mem_ack coincident with rst SHALL be ignored.
REQ-031 Outside MEM, mem_req and mem_we SHALL be 0; outside an active beat or WB, reg_idx SHALL be 0.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL enter IDLE, clear counters and the mask, and abandon any operation in progress.
- Outputs are then 0 except ir_ready=1.
REQ-033 After a reset mid-MEM, mem_req SHALL be 0 from the cycle following the reset edge, and no instr_done pulse is produced for the abandoned instruction.

Verification
REQ-034 Data-processing: ir=0xE0812003 (ADD r2), itype=7, cond_pass=1 accepted at edge N -> alu_en in cycle N+1, rf_we with reg_idx=2 in N+2, instr_done in N+3, ir_ready=1 in N+4.
REQ-035 Compare: ir=0xE1510002 (CMP), itype=7 -> the WB cycle has rf_we=0 and instr_done still occurs.
REQ-036 Block load: ir=0xE8BD0015 (LDM r0,r2,r4), mem_ack delayed 2 cycles per beat -> reg_idx sequence 0, 2, 4, with rf_we only on the ack cycles, then instr_done.
REQ-037 Long multiply: itype=1, MULL_CYCLES=3 -> 3 alu_en cycles, then WB with reg_idx=ir[15:12] followed by ir[19:16], then instr_done.
REQ-038 Undefined and condition fail:
- itype=12 -> undef_trap one cycle, then instr_done, with no mem_req.
- cond_pass=0 with any itype -> instr_done with no other strobes.
REQ-039 Reset mid-block: rst during the second beat -> IDLE the next cycle, mem_req=0, ir_ready=1, and no instr_done.
